// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared states, select codes and control decode for the snake body sequencer
package snake_pkg;

    typedef enum logic [3:0] {
        ST_CLEAR     = 4'd0,
        ST_INIT      = 4'd1,
        ST_RENDER_LD = 4'd2,
        ST_RENDER    = 4'd3,
        ST_FOOD      = 4'd4,
        ST_STEP      = 4'd5,
        ST_SHIFT_LD  = 4'd6,
        ST_SHIFT_WR  = 4'd7,
        ST_WAIT      = 4'd8,
        ST_HEAD      = 4'd9
    } snake_state_e;

    // Body-RAM write-data select
    localparam logic [1:0] SEL_DEFAULT = 2'd0;
    localparam logic [1:0] SEL_HEAD    = 2'd1;
    localparam logic [1:0] SEL_PREV    = 2'd2;

    // Pixel source select
    localparam logic [1:0] SRC_BODY = 2'd0;
    localparam logic [1:0] SRC_HEAD = 2'd1;
    localparam logic [1:0] SRC_FOOD = 2'd2;

    typedef struct packed {
        logic       ram_we;
        logic [1:0] ram_sel;
        logic       curr_ld;
        logic       prev_ld;
        logic       head_ld;
        logic       draw_en;
        logic [1:0] draw_src;
    } snake_ctl_t;

    // Strobes belonging to a state; everything not listed stays 0
    function automatic snake_ctl_t ctl_decode(snake_state_e st);
        snake_ctl_t c;
        c = '0;
        case (st)
            ST_CLEAR, ST_INIT: begin
                c.ram_we  = 1'b1;
                c.ram_sel = SEL_DEFAULT;
            end
            ST_RENDER_LD, ST_SHIFT_LD: c.curr_ld = 1'b1;
            ST_RENDER: begin
                c.draw_en  = 1'b1;
                c.draw_src = SRC_BODY;
            end
            ST_FOOD: begin
                c.draw_en  = 1'b1;
                c.draw_src = SRC_FOOD;
            end
            ST_HEAD: begin
                c.draw_en  = 1'b1;
                c.draw_src = SRC_HEAD;
            end
            ST_STEP: begin
                c.head_ld = 1'b1;
                c.prev_ld = 1'b1;
                c.ram_sel = SEL_HEAD;
            end
            ST_SHIFT_WR: begin
                c.ram_we  = 1'b1;
                c.ram_sel = SEL_PREV;
                c.prev_ld = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/snake_tile_cnt.sv
// rtl/snake_tile_cnt.sv - pixel-within-tile counter with last-pixel flag
module snake_tile_cnt #(
    parameter int PIX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [PIX_W-1:0] cnt_o,
    output logic             done_o
);

    logic [PIX_W-1:0] cnt_q;
    logic [PIX_W-1:0] cnt_d;

    // Count while enabled, wrapping to 0 after the last pixel so the next tile starts clean
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + PIX_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = en_i && (cnt_q == '1);

endmodule

// File: rtl/snake_body_seq.sv
// rtl/snake_body_seq.sv - snake body RAM clear/render/shift sequencer
module snake_body_seq
    import snake_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int MAX_LEN   = 1024,
    parameter int INIT_LEN  = 3,
    parameter int GROW_STEP = 5,
    parameter int PIX_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_done,
    input  logic              tick,
    input  logic              pause,
    input  logic              grow,
    input  logic              dead,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [1:0]        ram_sel,
    output logic              curr_ld,
    output logic              prev_ld,
    output logic              head_ld,
    output logic              draw_en,
    output logic [1:0]        draw_src,
    output logic [PIX_W-1:0]  pix_idx,
    output logic [ADDR_W:0]   length,
    output logic              full,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MAX_LEN - 1);
    localparam logic [ADDR_W:0]   MAX_LEN_V  = (ADDR_W+1)'(MAX_LEN);
    localparam logic [ADDR_W:0]   INIT_LEN_V = (ADDR_W+1)'(INIT_LEN);
    localparam logic [ADDR_W+1:0] GROW_V     = (ADDR_W+2)'(GROW_STEP);

    snake_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   len_q, len_d;
    snake_ctl_t        ctl_q;

    logic [ADDR_W:0]   addr_ext;
    logic [ADDR_W:0]   len_m1;
    logic              more_segs;
    logic [ADDR_W+1:0] grow_sum;
    logic              tile_en;
    logic              tile_done;
    logic [PIX_W-1:0]  pix_cnt;

    assign addr_ext  = {1'b0, addr_q};
    assign len_m1    = len_q - (ADDR_W+1)'(1);
    assign more_segs = addr_ext < len_m1;
    assign grow_sum  = {1'b0, len_q} + GROW_V;
    assign tile_en   = (state_q == ST_RENDER) || (state_q == ST_FOOD) || (state_q == ST_HEAD);

    snake_tile_cnt #(
        .PIX_W (PIX_W)
    ) u_tile_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (dead),
        .en_i   (tile_en),
        .cnt_o  (pix_cnt),
        .done_o (tile_done)
    );

    // Length: saturating grow, dead restores the starting length and wins over grow
    always_comb begin
        len_d = len_q;
        if (dead) begin
            len_d = INIT_LEN_V;
        end else if (grow) begin
            len_d = (grow_sum > {1'b0, MAX_LEN_V}) ? MAX_LEN_V : grow_sum[ADDR_W:0];
        end
    end

    // Next state and address; addr is parked at 0 in states that do not use it
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_CLEAR: begin
                // The cycle straight out of reset has no write, so the address holds
                // until a write actually happens and address 0 is never skipped.
                if (ctl_q.ram_we) begin
                    addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
                end
                if (clr_done) begin
                    state_d = ST_INIT;
                    addr_d  = '0;
                end
            end
            ST_INIT: begin
                if (more_segs) begin
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    state_d = ST_RENDER_LD;
                    addr_d  = '0;
                end
            end
            ST_RENDER_LD: state_d = ST_RENDER;
            ST_RENDER: begin
                if (tile_done) begin
                    if (more_segs) begin
                        state_d = ST_RENDER_LD;
                        addr_d  = addr_q + ADDR_W'(1);
                    end else begin
                        state_d = ST_FOOD;
                        addr_d  = '0;
                    end
                end
            end
            ST_FOOD: begin
                if (tile_done) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                state_d = ST_SHIFT_LD;
                addr_d  = '0;
            end
            ST_SHIFT_LD: state_d = ST_SHIFT_WR;
            ST_SHIFT_WR: begin
                if (more_segs) begin
                    state_d = ST_SHIFT_LD;
                    addr_d  = addr_q + ADDR_W'(1);
                end else begin
                    state_d = ST_WAIT;
                    addr_d  = '0;
                end
            end
            ST_WAIT: begin
                if (tick && !pause) begin
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (tile_done) begin
                    state_d = ST_RENDER_LD;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                addr_d  = '0;
            end
        endcase
        if (dead) begin
            state_d = ST_CLEAR;
            addr_d  = '0;
        end
    end

    // State, address, length and strobes; strobes are registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            addr_q  <= '0;
            len_q   <= INIT_LEN_V;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            ctl_q   <= ctl_decode(state_d);
        end
    end

    assign ram_addr = addr_q;
    assign ram_we   = ctl_q.ram_we;
    assign ram_sel  = ctl_q.ram_sel;
    assign curr_ld  = ctl_q.curr_ld;
    assign prev_ld  = ctl_q.prev_ld;
    assign head_ld  = ctl_q.head_ld;
    assign draw_en  = ctl_q.draw_en;
    assign draw_src = ctl_q.draw_src;
    assign pix_idx  = pix_cnt;
    assign length   = len_q;
    assign full     = (len_q == MAX_LEN_V);
    assign busy     = (state_q != ST_WAIT);

endmodule

// File: tb/tb_snake_body_seq.sv
// tb/tb_snake_body_seq.sv - randomized self-checking bench for snake_body_seq
`timescale 1ns/1ps
module tb_snake_body_seq;

    localparam int AW   = 4;
    localparam int ML   = 8;
    localparam int IL   = 3;
    localparam int GS   = 5;
    localparam int PW   = 4;
    localparam int TILE = 16;
    localparam logic [7:0] DEF = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr_done = 1'b0;
    logic          tick = 1'b0;
    logic          pause = 1'b0;
    logic          grow = 1'b0;
    logic          dead = 1'b0;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [1:0]    ram_sel;
    logic          curr_ld, prev_ld, head_ld;
    logic          draw_en;
    logic [1:0]    draw_src;
    logic [PW-1:0] pix_idx;
    logic [AW:0]   length;
    logic          full;
    logic          busy;

    always #5 clk = ~clk;

    snake_body_seq #(
        .ADDR_W(AW), .MAX_LEN(ML), .INIT_LEN(IL), .GROW_STEP(GS), .PIX_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .clr_done(clr_done), .tick(tick), .pause(pause),
        .grow(grow), .dead(dead), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_sel(ram_sel), .curr_ld(curr_ld), .prev_ld(prev_ld), .head_ld(head_ld),
        .draw_en(draw_en), .draw_src(draw_src), .pix_idx(pix_idx),
        .length(length), .full(full), .busy(busy)
    );

    // Environment: body RAM plus curr/prev/head registers driven by the DUT strobes
    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] head_r, curr_r, prev_r, wdata;
    assign wdata = (ram_sel == 2'd0) ? DEF : (ram_sel == 2'd1) ? head_r : prev_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r <= 8'd1;
            curr_r <= 8'd0;
            prev_r <= 8'd0;
        end else begin
            if (ram_we)  mem[ram_addr] <= wdata;
            if (curr_ld) curr_r <= mem[ram_addr];
            if (prev_ld) prev_r <= (ram_sel == 2'd1) ? head_r : curr_r;
            if (head_ld) head_r <= head_r + 8'd1;
        end
    end

    // Reference model: snake as an array of tiles, newest segment at index 0
    int         n_total = 0;
    int         n_bad = 0;
    int         mlen;
    logic [7:0] mhead;
    logic [7:0] body [0:ML-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ML; i++) body[i] = DEF;
        mlen = IL;
    endtask

    task automatic model_step();
        for (int i = ML - 1; i > 0; i--) if (i < mlen) body[i] = body[i-1];
        body[0] = mhead;
        mhead   = mhead + 8'd1;
    endtask

    task automatic model_grow();
        mlen = (mlen + GS > ML) ? ML : mlen + GS;
    endtask

    task automatic check_ram();
        int e = 0;
        for (int i = 0; i < mlen; i++) if (mem[i] !== body[i]) e++;
        chk("ram_body", 32'(e), 32'd0);
    endtask

    task automatic run_frame(output int nb, output int nf, output int nh, output int nw);
        int cyc = 0;
        nb = 0; nf = 0; nh = 0; nw = 0;
        do begin
            @(negedge clk);
            if (draw_en) begin
                if (draw_src == 2'd0) nb++;
                else if (draw_src == 2'd1) nh++;
                else if (draw_src == 2'd2) nf++;
            end
            if (ram_we && ram_sel == 2'd2) nw++;
            cyc++;
        end while (busy && cyc < 4000);
        if (cyc >= 4000) chk("frame_timeout", 32'd1, 32'd0);
    endtask

    task automatic frame_check(input int exp_head);
        int nb, nf, nh, nw;
        run_frame(nb, nf, nh, nw);
        chk("body_draws", 32'(nb), 32'(TILE * mlen));
        chk("food_draws", 32'(nf), 32'(TILE));
        chk("head_draws", 32'(nh), 32'(exp_head));
        chk("shift_writes", 32'(nw), 32'(mlen));
        model_step();
        check_ram();
        chk("len_after_frame", 32'(length), 32'(mlen));
        chk("full_after_frame", 32'(full), 32'(mlen == ML));
    endtask

    task automatic clear_and_first(input int ncyc);
        repeat (ncyc) @(negedge clk);
        clr_done = 1'b1;
        @(posedge clk); #1;
        clr_done = 1'b0;
        frame_check(0);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    task automatic pulse_grow();
        chk("grow_pre_len", 32'(length), 32'(mlen));
        grow = 1'b1;
        @(posedge clk); #1;
        grow = 1'b0;
        model_grow();
        chk("grow_len", 32'(length), 32'(mlen));
        chk("grow_full", 32'(full), 32'(mlen == ML));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int  found;
        int  cyc;
        model_clear();
        mhead = 8'd1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_pix", 32'(pix_idx), 32'd0);
        chk("rst_len", 32'(length), 32'(IL));
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_draw", 32'(draw_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        rst = 1'b0;

        // Clear sweep with address wrap, then the first frame
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("clr_addr", 32'(ram_addr), 32'((k - 1) % ML));
            chk("clr_we", 32'(ram_we), 32'd1);
            chk("clr_sel", 32'(ram_sel), 32'd0);
        end
        clr_done = 1'b1;
        @(posedge clk); #1;
        clr_done = 1'b0;
        frame_check(0);

        // Paused ticks are dropped
        pause = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick = (i % 2 == 0);
            @(posedge clk); #1;
            chk("pause_busy", 32'(busy), 32'd0);
            chk("pause_draw", 32'(draw_en), 32'd0);
        end
        tick = 1'b0;

        // Grow to the limit, then a saturated grow
        pulse_grow();
        pulse_grow();
        pause = 1'b0;
        pulse_tick();
        frame_check(TILE);

        // dead and grow together during a shift write
        pulse_tick();
        found = 0;
        cyc = 0;
        while (!found && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (ram_we && ram_sel == 2'd2 && ram_addr == AW'(1)) found = 1;
        end
        chk("shift_wr_seen", 32'(found), 32'd1);
        dead = 1'b1;
        grow = 1'b1;
        @(posedge clk); #1;
        dead = 1'b0;
        grow = 1'b0;
        chk("dead_busy", 32'(busy), 32'd1);
        chk("dead_we", 32'(ram_we), 32'd1);
        chk("dead_sel", 32'(ram_sel), 32'd0);
        chk("dead_addr", 32'(ram_addr), 32'd0);
        chk("dead_len", 32'(length), 32'(IL));
        chk("dead_pix", 32'(pix_idx), 32'd0);
        mhead = mhead + 8'd1;
        model_clear();
        clear_and_first(10);

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            int np;
            np = $urandom_range(0, 4);
            pause = 1'b1;
            for (int i = 0; i < np; i++) begin
                tick = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                chk("rnd_pause_busy", 32'(busy), 32'd0);
            end
            tick = 1'b0;
            if ($urandom_range(0, 2) == 0) pulse_grow();
            if ($urandom_range(0, 3) == 0) begin
                dead = 1'b1;
                @(posedge clk); #1;
                dead = 1'b0;
                chk("rnd_dead_len", 32'(length), 32'(IL));
                model_clear();
                pause = 1'b0;
                clear_and_first($urandom_range(10, 14));
            end else begin
                pause = 1'b0;
                pulse_tick();
                frame_check(TILE);
            end
        end

        // Asynchronous reset in the middle of a body tile
        pulse_tick();
        found = 0;
        cyc = 0;
        while (!found && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (draw_en && draw_src == 2'd0 && pix_idx == PW'(7)) found = 1;
        end
        chk("render_pix7_seen", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_pix", 32'(pix_idx), 32'd0);
        chk("arst_addr", 32'(ram_addr), 32'd0);
        chk("arst_draw", 32'(draw_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd1);
        chk("arst_len", 32'(length), 32'(IL));
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        mhead = 8'd1;
        clear_and_first(12);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
